// File: rtl/overlay_compositor_pkg.sv
// Shared constants, reset palette and sync payload for the overlay compositor.
package overlay_compositor_pkg;

    localparam int unsigned BG_ENTRIES = 4;
    localparam int unsigned LAYER_BASE = 4;
    localparam logic [23:0] LAYER_COLOR_RESET = 24'hFFFFFF;

    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
    } sync_t;

    // Background palette power-on values: empty/reserved black, dynamic green, static red.
    function automatic logic [23:0] bg_reset(input int unsigned idx);
        case (idx)
            1:       return 24'h00FF00;
            2:       return 24'hFF0000;
            default: return 24'h000000;
        endcase
    endfunction

endpackage

// File: rtl/overlay_compositor_if.sv
// Pixel stream, control masks and palette write port of the overlay compositor.
interface overlay_compositor_if #(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned COLOR_W    = 24,
    parameter int unsigned ADDR_W     = 4
);
    logic [1:0]            fb_class_in;
    logic [NUM_LAYERS-1:0] layer_pixel_in;
    logic [NUM_LAYERS-1:0] layer_en_in;
    logic [NUM_LAYERS-1:0] blink_en_in;
    logic                  active_in;
    logic                  hsync_in;
    logic                  vsync_in;
    logic                  pal_wr_en_in;
    logic [ADDR_W-1:0]     pal_wr_addr_in;
    logic [COLOR_W-1:0]    pal_wr_data_in;
    logic [COLOR_W-1:0]    pixel_out;
    logic                  active_out;
    logic                  hsync_out;
    logic                  vsync_out;
    logic                  blink_phase_out;

    modport master (
        output fb_class_in, layer_pixel_in, layer_en_in, blink_en_in,
               active_in, hsync_in, vsync_in,
               pal_wr_en_in, pal_wr_addr_in, pal_wr_data_in,
        input  pixel_out, active_out, hsync_out, vsync_out, blink_phase_out
    );

    modport slave (
        input  fb_class_in, layer_pixel_in, layer_en_in, blink_en_in,
               active_in, hsync_in, vsync_in,
               pal_wr_en_in, pal_wr_addr_in, pal_wr_data_in,
        output pixel_out, active_out, hsync_out, vsync_out, blink_phase_out
    );
endinterface

// File: rtl/overlay_compositor_palette_regs.sv
// Shadow/active palette register file; shadow is copied to active on commit,
// including any write landing in the commit cycle.
module overlay_compositor_palette_regs
    import overlay_compositor_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned COLOR_W    = 24,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 wr_en,
    input  logic [ADDR_W-1:0]                    wr_addr,
    input  logic [COLOR_W-1:0]                   wr_data,
    input  logic                                 commit,
    output logic [BG_ENTRIES-1:0][COLOR_W-1:0]   bg_pal,
    output logic [NUM_LAYERS-1:0][COLOR_W-1:0]   layer_col
);
    localparam int unsigned PAL_ENTRIES = LAYER_BASE + NUM_LAYERS;

    logic [BG_ENTRIES-1:0][COLOR_W-1:0] bg_shadow;
    logic [BG_ENTRIES-1:0][COLOR_W-1:0] bg_next;
    logic [NUM_LAYERS-1:0][COLOR_W-1:0] layer_shadow;
    logic [NUM_LAYERS-1:0][COLOR_W-1:0] layer_next;
    logic                               in_range_c;

    assign in_range_c = wr_en && (32'(wr_addr) < PAL_ENTRIES);

    // Shadow contents after this cycle's write; also the value committed on a vsync edge.
    always_comb begin
        bg_next    = bg_shadow;
        layer_next = layer_shadow;
        if (in_range_c) begin
            for (int unsigned i = 0; i < BG_ENTRIES; i++) begin
                if (32'(wr_addr) == i) bg_next[i] = wr_data;
            end
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                if (32'(wr_addr) == LAYER_BASE + i) layer_next[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BG_ENTRIES; i++) begin
                bg_shadow[i] <= COLOR_W'(bg_reset(i));
                bg_pal[i]    <= COLOR_W'(bg_reset(i));
            end
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                layer_shadow[i] <= COLOR_W'(LAYER_COLOR_RESET);
                layer_col[i]    <= COLOR_W'(LAYER_COLOR_RESET);
            end
        end else begin
            bg_shadow    <= bg_next;
            layer_shadow <= layer_next;
            if (commit) begin
                bg_pal    <= bg_next;
                layer_col <= layer_next;
            end
        end
    end

endmodule

// File: rtl/overlay_compositor.sv
// Two-stage pixel compositor: palette-mapped background with prioritised,
// blinkable overlay layers; masks and palette commit on the vsync rising edge.
module overlay_compositor
    import overlay_compositor_pkg::*;
#(
    parameter int unsigned NUM_LAYERS   = 4,
    parameter int unsigned COLOR_W      = 24,
    parameter int unsigned BLINK_FRAMES = 16,
    parameter int unsigned ADDR_W       = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    overlay_compositor_if.slave   bus
);
    localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    logic                               vsync_prev;
    logic                               vs_rise_c;
    logic [CNT_W-1:0]                   frame_cnt;
    logic                               blink_phase;
    logic [NUM_LAYERS-1:0]              en_mask;
    logic [NUM_LAYERS-1:0]              blink_mask;
    logic [NUM_LAYERS-1:0]              hit_c;
    logic                               win_any_c;
    logic [IDX_W-1:0]                   win_idx_c;
    logic [BG_ENTRIES-1:0][COLOR_W-1:0] bg_pal;
    logic [NUM_LAYERS-1:0][COLOR_W-1:0] layer_col;
    sync_t                              s1_sync;
    logic [COLOR_W-1:0]                 s1_bg;
    logic                               s1_hit;
    logic [IDX_W-1:0]                   s1_idx;

    assign vs_rise_c = bus.vsync_in & ~vsync_prev;

    overlay_compositor_palette_regs #(
        .NUM_LAYERS (NUM_LAYERS),
        .COLOR_W    (COLOR_W),
        .ADDR_W     (ADDR_W)
    ) u_palette (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .wr_en     (bus.pal_wr_en_in),
        .wr_addr   (bus.pal_wr_addr_in),
        .wr_data   (bus.pal_wr_data_in),
        .commit    (vs_rise_c),
        .bg_pal    (bg_pal),
        .layer_col (layer_col)
    );

    // Visible layers; the highest-index hit wins.
    always_comb begin
        hit_c     = bus.layer_pixel_in & en_mask & ~(blink_mask & {NUM_LAYERS{blink_phase}});
        win_any_c = 1'b0;
        win_idx_c = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (hit_c[i]) begin
                win_any_c = 1'b1;
                win_idx_c = IDX_W'(i);
            end
        end
    end

    // Frame-level control: edge detect, mask sampling and blink counter.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vsync_prev  <= 1'b0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            en_mask     <= '1;
            blink_mask  <= '0;
        end else begin
            vsync_prev <= bus.vsync_in;
            if (vs_rise_c) begin
                en_mask    <= bus.layer_en_in;
                blink_mask <= bus.blink_en_in;
                if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end
            end
        end
    end

    // S1 captures syncs, background colour and winning layer; S2 forms the output.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_sync        <= '0;
            s1_bg          <= '0;
            s1_hit         <= 1'b0;
            s1_idx         <= '0;
            bus.pixel_out  <= '0;
            bus.active_out <= 1'b0;
            bus.hsync_out  <= 1'b0;
            bus.vsync_out  <= 1'b0;
        end else begin
            s1_sync        <= '{active: bus.active_in, hsync: bus.hsync_in, vsync: bus.vsync_in};
            s1_bg          <= bg_pal[bus.fb_class_in];
            s1_hit         <= win_any_c;
            s1_idx         <= win_idx_c;
            bus.pixel_out  <= !s1_sync.active ? '0 : (s1_hit ? layer_col[s1_idx] : s1_bg);
            bus.active_out <= s1_sync.active;
            bus.hsync_out  <= s1_sync.hsync;
            bus.vsync_out  <= s1_sync.vsync;
        end
    end

    assign bus.blink_phase_out = blink_phase;

endmodule

// File: tb/tb_overlay_compositor.sv
// Directed bench for overlay_compositor with BLINK_FRAMES=2 and hand-computed colours.
module tb_overlay_compositor;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    overlay_compositor_if #(.NUM_LAYERS(4), .COLOR_W(24), .ADDR_W(4)) bus ();

    overlay_compositor #(
        .NUM_LAYERS   (4),
        .COLOR_W      (24),
        .BLINK_FRAMES (2),
        .ADDR_W       (4)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) @(negedge clk_in);
    endtask

    // Present one steady active pixel and check it two cycles later.
    task automatic pix(input string tag, input logic [1:0] cls, input logic [3:0] lay,
                       input logic [23:0] exp);
        bus.fb_class_in    = cls;
        bus.layer_pixel_in = lay;
        bus.active_in      = 1'b1;
        bus.vsync_in       = 1'b0;
        tick(2);
        check(tag, 32'(bus.pixel_out), 32'(exp));
    endtask

    task automatic pal_write(input logic [3:0] addr, input logic [23:0] data);
        bus.pal_wr_en_in   = 1'b1;
        bus.pal_wr_addr_in = addr;
        bus.pal_wr_data_in = data;
        tick(1);
        bus.pal_wr_en_in   = 1'b0;
    endtask

    task automatic vsync_pulse(input int len);
        bus.active_in = 1'b0;
        bus.vsync_in  = 1'b1;
        tick(len);
        bus.vsync_in  = 1'b0;
        tick(1);
    endtask

    initial begin
        bus.fb_class_in    = 2'd2;
        bus.layer_pixel_in = '0;
        bus.layer_en_in    = 4'b1111;
        bus.blink_en_in    = 4'b0000;
        bus.active_in      = 1'b1;
        bus.hsync_in       = 1'b1;
        bus.vsync_in       = 1'b0;
        bus.pal_wr_en_in   = 1'b0;
        bus.pal_wr_addr_in = '0;
        bus.pal_wr_data_in = '0;
        tick(3);
        check("rst_pixel", 32'(bus.pixel_out), 32'h0);
        check("rst_active", 32'(bus.active_out), 32'h0);
        check("rst_hsync", 32'(bus.hsync_out), 32'h0);
        check("rst_phase", 32'(bus.blink_phase_out), 32'h0);
        bus.hsync_in = 1'b0;
        rst_n_in = 1'b1;

        pix("bg_class1", 2'd1, 4'b0000, 24'h00FF00);
        pix("bg_class2", 2'd2, 4'b0000, 24'hFF0000);
        pix("bg_class0", 2'd0, 4'b0000, 24'h000000);
        pix("layer_default", 2'd2, 4'b0001, 24'hFFFFFF);

        // Sync and active travel through exactly two stages.
        bus.hsync_in = 1'b1;
        tick(1);
        check("hsync_d1", 32'(bus.hsync_out), 32'h0);
        tick(1);
        check("hsync_d2", 32'(bus.hsync_out), 32'h1);
        bus.hsync_in  = 1'b0;
        bus.active_in = 1'b0;
        tick(1);
        check("active_d1", 32'(bus.active_out), 32'h1);
        tick(1);
        check("active_d2", 32'(bus.active_out), 32'h0);
        check("blank_pixel", 32'(bus.pixel_out), 32'h0);

        // Mid-frame writes stay in the shadow until the next vsync edge.
        pal_write(4'd4, 24'h111111);
        pal_write(4'd7, 24'h777777);
        pal_write(4'd1, 24'h0000FF);
        pix("shadow_bg", 2'd1, 4'b0000, 24'h00FF00);
        pix("shadow_layer", 2'd0, 4'b1001, 24'hFFFFFF);
        vsync_pulse(3);                                       // edge 1
        check("phase_e1", 32'(bus.blink_phase_out), 32'h0);
        pix("commit_bg", 2'd1, 4'b0000, 24'h0000FF);
        pix("prio_l3", 2'd0, 4'b1001, 24'h777777);

        bus.layer_en_in = 4'b0111;
        vsync_pulse(3);                                       // edge 2: phase 1
        check("phase_e2", 32'(bus.blink_phase_out), 32'h1);
        pix("l3_disabled", 2'd0, 4'b1001, 24'h111111);

        bus.blink_en_in = 4'b0001;
        bus.active_in   = 1'b0;
        bus.vsync_in    = 1'b1;
        tick(2);
        check("vsync_d2", 32'(bus.vsync_out), 32'h1);
        tick(8);
        bus.vsync_in = 1'b0;
        tick(1);                                              // edge 3 (10-cycle pulse)
        check("phase_e3", 32'(bus.blink_phase_out), 32'h1);
        pix("blink_hidden", 2'd2, 4'b0001, 24'hFF0000);

        // Out-of-range writes, then a write landing on the edge cycle itself.
        pal_write(4'd8, 24'h123456);
        pal_write(4'd15, 24'h654321);
        bus.layer_en_in    = 4'b1111;
        bus.active_in      = 1'b0;
        bus.vsync_in       = 1'b1;
        bus.pal_wr_en_in   = 1'b1;
        bus.pal_wr_addr_in = 4'd2;
        bus.pal_wr_data_in = 24'hABCDEF;
        tick(1);                                              // edge 4: phase 0
        bus.pal_wr_en_in = 1'b0;
        tick(3);
        bus.vsync_in = 1'b0;
        tick(1);
        check("phase_e4", 32'(bus.blink_phase_out), 32'h0);
        pix("edge_write", 2'd2, 4'b0000, 24'hABCDEF);
        pix("blink_shown", 2'd2, 4'b0001, 24'h111111);
        pix("oor_l1", 2'd0, 4'b0010, 24'hFFFFFF);
        pix("oor_l2", 2'd0, 4'b0100, 24'hFFFFFF);
        pix("oor_l3", 2'd0, 4'b1000, 24'h777777);
        pix("oor_bg0", 2'd0, 4'b0000, 24'h000000);
        pix("oor_bg3", 2'd3, 4'b0000, 24'h000000);

        // Asynchronous reset mid-line with an uncommitted write pending.
        pal_write(4'd1, 24'h555555);
        bus.fb_class_in = 2'd2;
        bus.hsync_in    = 1'b1;
        bus.active_in   = 1'b1;
        tick(3);
        #2 rst_n_in = 1'b0;
        #1;
        check("arst_pixel", 32'(bus.pixel_out), 32'h0);
        check("arst_hsync", 32'(bus.hsync_out), 32'h0);
        check("arst_active", 32'(bus.active_out), 32'h0);
        check("arst_phase", 32'(bus.blink_phase_out), 32'h0);
        tick(2);
        bus.hsync_in = 1'b0;
        rst_n_in = 1'b1;
        pix("post_rst_bg1", 2'd1, 4'b0000, 24'h00FF00);
        pix("post_rst_bg2", 2'd2, 4'b0000, 24'hFF0000);
        pix("post_rst_l3", 2'd0, 4'b1000, 24'hFFFFFF);
        vsync_pulse(2);
        pix("lost_shadow", 2'd1, 4'b0000, 24'h00FF00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
